snake_game_ctrl: RTL

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_game_ctrl_if.sv | 38 +++
 rtl/snake_game_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl_if.sv
// Control bus between the snake game controller and its datapath / apple generator.
// master drives the game inputs, slave is the controller.
interface snake_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic [3:0] switches_p1;
  logic [3:0] switches_p2;
  logic       eat_p1;
  logic       eat_p2;
  logic       collide_p1;
  logic       collide_p2;
  logic       apple_ack;

  logic       step;
  logic [1:0] move_p1;
  logic [1:0] move_p2;
  logic       grow_p1;
  logic       grow_p2;
  logic       apple_req;
  logic [2:0] len_p1;
  logic [2:0] len_p2;
  logic [1:0] state;
  logic [1:0] winner;

  modport master (
    output frame_tick, start, switches_p1, switches_p2,
           eat_p1, eat_p2, collide_p1, collide_p2, apple_ack,
    input  step, move_p1, move_p2, grow_p1, grow_p2,
           apple_req, len_p1, len_p2, state, winner
  );

  modport slave (
    input  frame_tick, start, switches_p1, switches_p2,
           eat_p1, eat_p2, collide_p1, collide_p2, apple_ack,
    output step, move_p1, move_p2, grow_p1, grow_p2,
           apple_req, len_p1, len_p2, state, winner
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Two-player snake game controller: game FSM, move pacing, direction commit,
// apple arbitration and tail length bookkeeping.
module snake_game_ctrl #(
  parameter int unsigned SPEED   = 3,
  parameter int unsigned MAX_LEN = 5
) (
  input logic              clk,
  input logic              reset,
  snake_game_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned LEN_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(2);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Reset asserts immediately, releases two clocks after reset goes high.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Highest-priority request wins; reversing the committed move is refused.
  function automatic logic [1:0] pick_dir(input logic [3:0] sw,
                                          input logic [1:0] pend,
                                          input logic [1:0] committed);
    logic [1:0] req;
    req = pend;
    if      (sw[1]) req = DIR_RIGHT;
    else if (sw[0]) req = DIR_LEFT;
    else if (sw[2]) req = DIR_UP;
    else if (sw[3]) req = DIR_DOWN;
    if (sw == 4'd0 || req == (committed ^ 2'd1)) return pend;
    return req;
  endfunction

  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len);
    return (len >= LEN_MAX) ? LEN_MAX : len + LEN_W'(1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [1:0]       pend_p1;
  logic [1:0]       pend_p2;
  logic             tie_p2;
  logic             start_q;
  logic             step_q;
  logic             grow_p1_q;
  logic             grow_p2_q;
  logic             apple_req_q;
  logic [1:0]       move_p1_q;
  logic [1:0]       move_p2_q;
  logic [1:0]       winner_q;
  logic [LEN_W-1:0] len_p1_q;
  logic [LEN_W-1:0] len_p2_q;

  logic collide_c;
  logic step_c;
  logic eat_ok_c;
  logic eat_both_c;
  logic grant_p1_c;
  logic grant_p2_c;

  // A grow still in flight counts as a claimed apple, so one apple is never granted twice.
  always_comb begin
    collide_c  = bus.collide_p1 | bus.collide_p2;
    step_c     = (state_q == ST_PLAY) && bus.frame_tick && (frame_cnt == CNT_LAST) && !collide_c;
    eat_ok_c   = step_c && !apple_req_q && !grow_p1_q && !grow_p2_q;
    eat_both_c = bus.eat_p1 & bus.eat_p2;
    grant_p1_c = eat_ok_c && bus.eat_p1 && (!bus.eat_p2 || !tie_p2);
    grant_p2_c = eat_ok_c && bus.eat_p2 && (!bus.eat_p1 || tie_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt   <= '0;
      pend_p1     <= DIR_RIGHT;
      pend_p2     <= DIR_LEFT;
      tie_p2      <= 1'b0;
      start_q     <= 1'b0;
      step_q      <= 1'b0;
      grow_p1_q   <= 1'b0;
      grow_p2_q   <= 1'b0;
      apple_req_q <= 1'b0;
      move_p1_q   <= DIR_RIGHT;
      move_p2_q   <= DIR_LEFT;
      winner_q    <= 2'd0;
      len_p1_q    <= LEN_INIT;
      len_p2_q    <= LEN_INIT;
    end else begin
      step_q    <= step_c;
      grow_p1_q <= grant_p1_c;
      grow_p2_q <= grant_p2_c;
      start_q   <= bus.start;
      pend_p1   <= pick_dir(bus.switches_p1, pend_p1, move_p1_q);
      pend_p2   <= pick_dir(bus.switches_p2, pend_p2, move_p2_q);

      if (apple_req_q && bus.apple_ack) apple_req_q <= 1'b0;
      else if (grow_p1_q || grow_p2_q)  apple_req_q <= 1'b1;

      if (step_c) begin
        move_p1_q <= pend_p1;
        move_p2_q <= pend_p2;
      end
      if (grant_p1_c) len_p1_q <= len_inc(len_p1_q);
      if (grant_p2_c) len_p2_q <= len_inc(len_p2_q);
      if (eat_ok_c && eat_both_c) tie_p2 <= !tie_p2;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_PLAY;
            len_p1_q  <= LEN_INIT;
            len_p2_q  <= LEN_INIT;
            move_p1_q <= DIR_RIGHT;
            move_p2_q <= DIR_LEFT;
            pend_p1   <= DIR_RIGHT;
            pend_p2   <= DIR_LEFT;
            frame_cnt <= '0;
            tie_p2    <= 1'b0;
          end
        end
        ST_PLAY: begin
          // {collide_p1, collide_p2} maps directly onto the winner code.
          if (collide_c) begin
            state_q  <= ST_OVER;
            winner_q <= {bus.collide_p1, bus.collide_p2};
          end else if (bus.frame_tick) begin
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CNT_W'(1);
          end
        end
        ST_OVER: begin
          if (bus.start && !start_q) begin
            state_q  <= ST_IDLE;
            winner_q <= 2'd0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.step      = step_q;
  assign bus.move_p1   = move_p1_q;
  assign bus.move_p2   = move_p2_q;
  assign bus.grow_p1   = grow_p1_q;
  assign bus.grow_p2   = grow_p2_q;
  assign bus.apple_req = apple_req_q;
  assign bus.len_p1    = len_p1_q;
  assign bus.len_p2    = len_p2_q;
  assign bus.state     = 2'(state_q);
  assign bus.winner    = winner_q;

endmodule
